// File: rtl/qos_wrr_tl_pkg.sv
// Shared constants and helpers for the parametrised QoS transaction layer.
// Imported by the interface, the per-VC FIFO and the top.
package qos_wrr_tl_pkg;

  localparam logic [1:0] ST_RESET  = 2'd0;
  localparam logic [1:0] ST_INIT   = 2'd1;
  localparam logic [1:0] ST_IDLE   = 2'd2;
  localparam logic [1:0] ST_ACTIVE = 2'd3;

  localparam logic MODE_WRR = 1'b0;
  localparam logic MODE_SP  = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int def_tl();
    return 1;
  endfunction

  function automatic int def_th(input int depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/qos_wrr_tl_if.sv
// Push/config/pop bundle between ingress, the QoS layer and the link layer.
// The slave side is the QoS layer itself.
interface qos_wrr_tl_if
  import qos_wrr_tl_pkg::*;
#(
  parameter int NVC   = 4,
  parameter int DW    = 4,
  parameter int DEPTH = 8,
  parameter int WW    = 2
) ();
  localparam int IDW = clog2(NVC);
  localparam int CW  = clog2(DEPTH + 1);

  logic              SET_INIT;
  logic              PUSH;
  logic [IDW-1:0]    PUSH_ID;
  logic [DW-1:0]     DATA_IN;
  logic [CW-1:0]     TL_IN;
  logic [CW-1:0]     TH_IN;
  logic              MODE;
  logic [NVC*WW-1:0] WEIGHTS;
  logic              POP;
  logic [DW-1:0]     DATA_OUT;
  logic              DATA_VALID;
  logic [IDW-1:0]    DATA_VC;
  logic              IDLE;
  logic [NVC-1:0]    PAUSE_STB;
  logic [NVC-1:0]    CONTINUE_STB;
  logic [NVC-1:0]    ERROR_FULL;

  modport master (
    output SET_INIT, PUSH, PUSH_ID, DATA_IN,
    output TL_IN, TH_IN, MODE, WEIGHTS, POP,
    input  DATA_OUT, DATA_VALID, DATA_VC, IDLE,
    input  PAUSE_STB, CONTINUE_STB, ERROR_FULL
  );

  modport slave (
    input  SET_INIT, PUSH, PUSH_ID, DATA_IN,
    input  TL_IN, TH_IN, MODE, WEIGHTS, POP,
    output DATA_OUT, DATA_VALID, DATA_VC, IDLE,
    output PAUSE_STB, CONTINUE_STB, ERROR_FULL
  );

endinterface

// File: rtl/qos_wrr_tl_vc_fifo.sv
// Single virtual-channel synchronous FIFO with occupancy count.
// A push on a full FIFO is taken only when a pop frees a slot in the same cycle.
module qos_wrr_tl_vc_fifo
  import qos_wrr_tl_pkg::*;
#(
  parameter  int DW    = 4,
  parameter  int DEPTH = 8,
  localparam int AW    = clog2(DEPTH),
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          wr, rd;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign wr      = push_i && (!full_o || pop_i);
  assign rd      = pop_i && !empty_o;
  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr) wptr_q <= wptr_q + 1'b1;
      if (rd) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(wr) - CW'(rd);
    end
  end

  // Storage needs no reset; the count alone defines which words are live.
  always_ff @(posedge clk) begin
    if (wr && !flush_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/qos_wrr_tl.sv
// QoS transaction layer: NVC per-VC FIFOs, pause/continue thresholds,
// single output port arbitrated by weighted round robin or strict priority.
module qos_wrr_tl
  import qos_wrr_tl_pkg::*;
#(
  parameter int NVC   = 4,
  parameter int DW    = 4,
  parameter int DEPTH = 8,
  parameter int WW    = 2
) (
  input logic         CLOCK,
  input logic         RESET,
  qos_wrr_tl_if.slave bus
);

  localparam int IDW = clog2(NVC);
  localparam int CW  = clog2(DEPTH + 1);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     tl_q, th_q;
  logic              mode_q, thr_en_q;
  logic [NVC*WW-1:0] wgt_q;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [WW-1:0]     cred_q, cred_d;
  logic [NVC-1:0]    paused_q, paused_d;
  logic [NVC-1:0]    pstb_q, pstb_d;
  logic [NVC-1:0]    cstb_q, cstb_d;
  logic [NVC-1:0]    err_q, err_d;
  logic [DW-1:0]     dout_q, dout_d;
  logic              dval_q, dval_d;
  logic [IDW-1:0]    dvc_q, dvc_d;

  logic           in_init, live, run, any, do_pop;
  logic           wrr, stay;
  logic [NVC-1:0] f_push, f_pop, f_full, f_empty, nonempty;
  logic [DW-1:0]  f_rdata [NVC];
  logic [CW-1:0]  f_cnt [NVC];
  logic [IDW-1:0] sp_g, rr_g, rr_idx, g;

  function automatic logic [WW-1:0] weff(input logic [WW-1:0] w);
    return (w == '0) ? WW'(1) : w;
  endfunction

  assign in_init  = (state_q == ST_INIT);
  assign live     = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
  assign run      = live && !bus.SET_INIT;
  assign nonempty = ~f_empty;
  assign any      = |nonempty;
  assign do_pop   = run && bus.POP && any;

  for (genvar i = 0; i < NVC; i++) begin : g_vc
    qos_wrr_tl_vc_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk     (CLOCK),
      .rst_n   (RESET),
      .flush_i (in_init),
      .push_i  (f_push[i]),
      .pop_i   (f_pop[i]),
      .data_i  (bus.DATA_IN),
      .data_o  (f_rdata[i]),
      .count_o (f_cnt[i]),
      .full_o  (f_full[i]),
      .empty_o (f_empty[i])
    );
  end

  always_comb begin
    sp_g = '0;
    for (int i = NVC - 1; i >= 0; i--) begin
      if (nonempty[i]) sp_g = IDW'(i);
    end
  end

  // Walk ptr+NVC down to ptr+1 so the closest non-empty VC wins.
  always_comb begin
    rr_g   = ptr_q;
    rr_idx = '0;
    for (int k = NVC; k >= 1; k--) begin
      rr_idx = ptr_q + IDW'(k);
      if (nonempty[rr_idx]) rr_g = rr_idx;
    end
  end

  assign wrr  = do_pop && (mode_q == MODE_WRR);
  assign stay = nonempty[ptr_q] && (cred_q != '0);

  always_comb begin
    g = rr_g;
    if (mode_q == MODE_SP) g = sp_g;
    else if (stay)         g = ptr_q;
  end

  // A fresh round after config starts on VC0 with its full weight.
  always_comb begin
    ptr_d  = ptr_q;
    cred_d = cred_q;
    unique case (1'b1)
      in_init: begin
        ptr_d  = '0;
        cred_d = weff(bus.WEIGHTS[WW-1:0]);
      end
      wrr && stay: begin
        cred_d = cred_q - 1'b1;
      end
      wrr && !stay: begin
        ptr_d  = rr_g;
        cred_d = weff(wgt_q[int'(rr_g)*WW +: WW]) - 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    f_pop = '0;
    for (int i = 0; i < NVC; i++) begin
      f_pop[i] = do_pop && (g == IDW'(i));
    end
  end

  always_comb begin
    f_push = '0;
    err_d  = '0;
    for (int i = 0; i < NVC; i++) begin
      if (run && bus.PUSH && (bus.PUSH_ID == IDW'(i))) begin
        if (f_full[i] && !f_pop[i]) err_d[i]  = 1'b1;
        else                        f_push[i] = 1'b1;
      end
    end
  end

  always_comb begin
    logic [CW-1:0] cnt_n;
    cnt_n    = '0;
    paused_d = paused_q;
    pstb_d   = '0;
    cstb_d   = '0;
    for (int i = 0; i < NVC; i++) begin
      cnt_n = f_cnt[i] + CW'(f_push[i]) - CW'(f_pop[i]);
      if (in_init) begin
        paused_d[i] = 1'b0;
      end else if (thr_en_q) begin
        if ((f_cnt[i] < th_q) && (cnt_n >= th_q)) begin
          pstb_d[i]   = 1'b1;
          paused_d[i] = 1'b1;
        end else if (paused_q[i] && (cnt_n < f_cnt[i])
                     && (cnt_n <= tl_q)) begin
          cstb_d[i]   = 1'b1;
          paused_d[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    dout_d = dout_q;
    dval_d = 1'b0;
    dvc_d  = dvc_q;
    if (do_pop) begin
      dout_d = f_rdata[g];
      dval_d = 1'b1;
      dvc_d  = g;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!bus.SET_INIT) state_d = ST_IDLE;
      ST_IDLE:   if (any) state_d = ST_ACTIVE;
      ST_ACTIVE: if (!any) state_d = ST_IDLE;
      default:   state_d = ST_RESET;
    endcase
    if (bus.SET_INIT) state_d = ST_INIT;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      tl_q     <= CW'(def_tl());
      th_q     <= CW'(def_th(DEPTH));
      mode_q   <= MODE_WRR;
      thr_en_q <= 1'b1;
      wgt_q    <= {NVC{WW'(1)}};
    end else if (in_init) begin
      tl_q     <= bus.TL_IN;
      th_q     <= bus.TH_IN;
      mode_q   <= bus.MODE;
      wgt_q    <= bus.WEIGHTS;
      thr_en_q <= (bus.TL_IN < bus.TH_IN)
                  && (bus.TH_IN <= CW'(DEPTH));
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_RESET;
      ptr_q    <= '0;
      cred_q   <= WW'(1);
      paused_q <= '0;
      pstb_q   <= '0;
      cstb_q   <= '0;
      err_q    <= '0;
      dout_q   <= '0;
      dval_q   <= 1'b0;
      dvc_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cred_q   <= cred_d;
      paused_q <= paused_d;
      pstb_q   <= pstb_d;
      cstb_q   <= cstb_d;
      err_q    <= err_d;
      dout_q   <= dout_d;
      dval_q   <= dval_d;
      dvc_q    <= dvc_d;
    end
  end

  assign bus.DATA_OUT     = dout_q;
  assign bus.DATA_VALID   = dval_q;
  assign bus.DATA_VC      = dvc_q;
  assign bus.IDLE         = live && !any;
  assign bus.PAUSE_STB    = pstb_q;
  assign bus.CONTINUE_STB = cstb_q;
  assign bus.ERROR_FULL   = err_q;

endmodule

// File: tb/tb_qos_wrr_tl.sv
// Directed bench for qos_wrr_tl: stimulus queues expected pops,
// a negedge monitor compares every DATA_VALID word against the queue.
module tb_qos_wrr_tl;
  import qos_wrr_tl_pkg::*;

  localparam int NVC   = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 8;
  localparam int WW    = 2;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic [1:0] exp_vc  [$];
  logic [3:0] exp_dat [$];
  logic [3:0] mdl [NVC][$];

  int seq3 [32] = '{0,0,1,2,2,2,3,
                    0,0,1,2,2,2,3,
                    0,0,1,2,2,3,
                    0,0,1,3,1,3,1,3,1,3,1,3};

  qos_wrr_tl_if #(.NVC(NVC), .DW(DW), .DEPTH(DEPTH), .WW(WW)) bus ();

  qos_wrr_tl #(.NVC(NVC), .DW(DW), .DEPTH(DEPTH), .WW(WW)) dut (
    .CLOCK (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.DATA_OUT, bus.DATA_VALID, bus.DATA_VC, bus.IDLE,
                bus.PAUSE_STB, bus.CONTINUE_STB, bus.ERROR_FULL});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int vc, input logic [3:0] d, input bit acc);
    bus.PUSH    = 1'b1;
    bus.PUSH_ID = 2'(vc);
    bus.DATA_IN = d;
    if (acc) mdl[vc].push_back(d);
    tick();
    bus.PUSH = 1'b0;
  endtask

  task automatic expect_pop(input int vc);
    exp_vc.push_back(2'(vc));
    exp_dat.push_back(mdl[vc].pop_front());
  endtask

  task automatic do_init(input logic [3:0] tl, input logic [3:0] th,
                         input logic md, input logic [7:0] w);
    bus.TL_IN    = tl;
    bus.TH_IN    = th;
    bus.MODE     = md;
    bus.WEIGHTS  = w;
    bus.SET_INIT = 1'b1;
    tick();
    tick();
    chk("idle_in_init", 32'(bus.IDLE), 0);
    bus.SET_INIT = 1'b0;
    for (int v = 0; v < NVC; v++) mdl[v].delete();
    tick();
    chk("idle_after_init", 32'(bus.IDLE), 1);
  endtask

  task automatic preload();
    for (int v = 0; v < NVC; v++)
      for (int k = 0; k < 8; k++) push(v, 4'(k + 8 * v), 1'b1);
  endtask

  task automatic drain_check(input string name);
    tick();
    tick();
    chk(name, 32'(exp_vc.size()), 0);
  endtask

  initial begin : monitor
    logic [1:0] ev;
    logic [3:0] ed;
    forever begin
      @(negedge clk);
      if (bus.DATA_VALID === 1'b1) begin
        if (exp_vc.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got vc=%0d data=%0h expected none",
                   bus.DATA_VC, bus.DATA_OUT);
        end else begin
          ev = exp_vc.pop_front();
          ed = exp_dat.pop_front();
          chk("pop_vc", 32'(bus.DATA_VC), 32'(ev));
          chk("pop_data", 32'(bus.DATA_OUT), 32'(ed));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n        = 1'b1;
    bus.SET_INIT = 1'b0;
    bus.PUSH     = 1'b0;
    bus.PUSH_ID  = '0;
    bus.DATA_IN  = '0;
    bus.TL_IN    = 4'd1;
    bus.TH_IN    = 4'd7;
    bus.MODE     = 1'b0;
    bus.WEIGHTS  = 8'h55;
    bus.POP      = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", outs(), 0);
    #10 rst_n = 1'b1;
    tick();
    chk("idle_first_init", 32'(bus.IDLE), 0);

    // 1: pause at count 6, continue at count 2, IDLE after drain
    do_init(4'd2, 4'd6, 1'b0, 8'h55);
    for (int k = 1; k <= 6; k++) begin
      push(1, 4'(k), 1'b1);
      chk("pause_stb", 32'(bus.PAUSE_STB), (k == 6) ? 32'h2 : 32'h0);
      chk("idle_busy", 32'(bus.IDLE), 0);
    end
    bus.POP = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      expect_pop(1);
      tick();
      chk("cont_stb", 32'(bus.CONTINUE_STB), (k == 4) ? 32'h2 : 32'h0);
      chk("idle_drain", 32'(bus.IDLE), (k == 6) ? 32'h1 : 32'h0);
    end
    bus.POP = 1'b0;
    drain_check("drain_t1");

    // 2: overflow of VC2 drops the 9th word
    for (int k = 1; k <= 9; k++) begin
      push(2, 4'(k), k <= 8);
      chk("err_full", 32'(bus.ERROR_FULL), (k == 9) ? 32'h4 : 32'h0);
    end
    bus.POP = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      expect_pop(2);
      tick();
    end
    tick();
    chk("empty_pop_t2", 32'(bus.DATA_VALID), 0);
    bus.POP = 1'b0;
    drain_check("drain_t2");

    // 3: WRR with weights 2,1,3,0
    do_init(4'd2, 4'd6, 1'b0, 8'h36);
    preload();
    bus.POP = 1'b1;
    for (int n = 0; n < 32; n++) begin
      expect_pop(seq3[n]);
      tick();
    end
    tick();
    chk("empty_pop_wrr", 32'(bus.DATA_VALID), 0);
    bus.POP = 1'b0;
    drain_check("drain_t3");

    // 4: strict priority drains VCs in index order
    do_init(4'd2, 4'd6, 1'b1, 8'h36);
    preload();
    bus.POP = 1'b1;
    for (int n = 0; n < 32; n++) begin
      expect_pop(n / 8);
      tick();
      chk("sp_valid", 32'(bus.DATA_VALID), 1);
    end
    bus.POP = 1'b0;
    drain_check("drain_t4");

    // 5: push+pop on a full VC0, then pop on empty
    for (int k = 1; k <= 8; k++) push(0, 4'(k), 1'b1);
    bus.POP = 1'b1;
    expect_pop(0);
    push(0, 4'd9, 1'b1);
    chk("no_err_full", 32'(bus.ERROR_FULL), 0);
    for (int k = 0; k < 8; k++) begin
      expect_pop(0);
      tick();
    end
    tick();
    chk("empty_pop_t5", 32'(bus.DATA_VALID), 0);
    bus.POP = 1'b0;
    chk("idle_t5", 32'(bus.IDLE), 1);
    drain_check("drain_t5");

    // 6: async reset mid-traffic
    for (int k = 0; k < 5; k++) push(3, 4'hA + 4'(k), 1'b1);
    bus.POP = 1'b1;
    expect_pop(3);
    tick();
    bus.POP  = 1'b0;
    bus.PUSH = 1'b1;
    bus.PUSH_ID = 2'd3;
    @(negedge clk);
    #1;
    chk("pre_reset_valid", 32'(bus.DATA_VALID), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 0);
    chk("async_reset_idle", 32'(bus.IDLE), 0);
    bus.PUSH = 1'b0;
    mdl[3].delete();
    #2 rst_n = 1'b1;
    tick();
    tick();
    chk("idle_after_reset", 32'(bus.IDLE), 1);
    bus.POP = 1'b1;
    tick();
    chk("empty_pop_t6", 32'(bus.DATA_VALID), 0);
    bus.POP = 1'b0;
    drain_check("drain_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
